writeback_queue: RTL and testbench

//   Producer-side writer for the 15-entry register file write port (wb_en/write_src_reg/wb_value).

---
 rtl/writeback_queue_if.sv | 22 ++
 rtl/writeback_queue.sv | 109 ++++++++++
 tb/tb_writeback_queue.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/writeback_queue_if.sv
// Producer-side push handshake for the writeback queue.
// The producer drives valid/dest/value; the queue answers with ready.
interface writeback_queue_if;
    logic        push_valid;
    logic        push_ready;
    logic [3:0]  push_dest;
    logic [31:0] push_value;

    modport master (
        output push_valid,
        output push_dest,
        output push_value,
        input  push_ready
    );

    modport slave (
        input  push_valid,
        input  push_dest,
        input  push_value,
        output push_ready
    );
endinterface

// File: rtl/writeback_queue.sv
// Buffers EXE/MEM results and retires one per cycle into the register file,
// with pending/forward lookups so decode can detect and bypass in-flight results.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                clk,
    input  logic                rst,
    writeback_queue_if.slave    push_bus,
    input  logic                freeze,
    output logic                wb_en,
    output logic [3:0]          write_src_reg,
    output logic [31:0]         wb_value,
    input  logic [3:0]          query_reg_1,
    input  logic [3:0]          query_reg_2,
    output logic                pending_1,
    output logic                pending_2,
    output logic [31:0]         fwd_data_1,
    output logic [31:0]         fwd_data_2,
    output logic [AW:0]         count
);

    localparam logic [3:0]  PC_REG = 4'hF;
    localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);

    logic [3:0]       dest_q  [DEPTH];
    logic [31:0]      value_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    logic             empty;
    logic             push_fire;
    logic             retire;

    logic [3:0]       qry   [2];
    logic [1:0]       pend;
    logic [31:0]      fwd   [2];
    logic [AW-1:0]    idx;

    assign empty     = (count == '0);
    assign push_bus.push_ready = (count != FULL);
    assign push_fire = push_bus.push_valid && push_bus.push_ready;
    assign retire    = !empty && !freeze;

    // Head is presented combinationally; the regfile captures it at negedge.
    assign write_src_reg = empty ? 4'h0  : dest_q[rd_ptr];
    assign wb_value      = empty ? 32'h0 : value_q[rd_ptr];
    assign wb_en         = retire && (dest_q[rd_ptr] != PC_REG);

    assign qry[0] = query_reg_1;
    assign qry[1] = query_reg_2;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        pend   = '0;
        fwd[0] = '0;
        fwd[1] = '0;
        idx    = '0;
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + AW'(i);
                if (valid_q[idx] &&
                    dest_q[idx] == qry[n] &&
                    qry[n] != PC_REG) begin
                    pend[n] = 1'b1;
                    fwd[n]  = value_q[idx];
                end
            end
        end
    end

    assign pending_1  = pend[0];
    assign pending_2  = pend[1];
    assign fwd_data_1 = fwd[0];
    assign fwd_data_2 = fwd[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i]  <= '0;
                value_q[i] <= '0;
            end
        end else begin
            if (retire) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + AW'(1);
            end
            // Full blocks a push even when the head retires this cycle,
            // so rd_ptr and wr_ptr never target the same slot here.
            if (push_fire) begin
                dest_q[wr_ptr]  <= push_bus.push_dest;
                value_q[wr_ptr] <= push_bus.push_value;
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + AW'(1);
            end
            case ({push_fire, retire})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue with a queue model and a write scoreboard.
module tb_writeback_queue;

    typedef struct {
        logic [3:0]  d;
        logic [31:0] v;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        wb_en;
    logic [3:0]  write_src_reg;
    logic [31:0] wb_value;
    logic [3:0]  query_reg_1;
    logic [3:0]  query_reg_2;
    logic        pending_1;
    logic        pending_2;
    logic [31:0] fwd_data_1;
    logic [31:0] fwd_data_2;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    ent_t mq[$];
    ent_t sbq[$];

    writeback_queue_if pif();

    writeback_queue #(.DEPTH(4), .AW(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .push_bus      (pif),
        .freeze        (freeze),
        .wb_en         (wb_en),
        .write_src_reg (write_src_reg),
        .wb_value      (wb_value),
        .query_reg_1   (query_reg_1),
        .query_reg_2   (query_reg_2),
        .pending_1     (pending_1),
        .pending_2     (pending_2),
        .fwd_data_1    (fwd_data_1),
        .fwd_data_2    (fwd_data_2),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_lookup(input logic [3:0] q, output logic p,
                                output logic [31:0] f);
        p = 1'b0;
        f = '0;
        if (q != 4'hF) begin
            foreach (mq[i]) begin
                if (mq[i].d == q) begin
                    p = 1'b1;
                    f = mq[i].v;
                end
            end
        end
    endtask

    task automatic cycle(input logic pv, input logic [3:0] pd,
                         input logic [31:0] pval, input logic frz);
        logic        exp_ready;
        logic        exp_en;
        logic        fire;
        logic        ret;
        logic        p;
        logic [31:0] f;
        ent_t        h;
        ent_t        w;
        pif.push_valid = pv;
        pif.push_dest  = pd;
        pif.push_value = pval;
        freeze         = frz;
        @(negedge clk);
        exp_ready = (mq.size() != 4);
        chk("push_ready", {31'b0, pif.push_ready}, {31'b0, exp_ready});
        chk("count", {29'b0, count}, mq.size());
        h.d = 4'h0;
        h.v = 32'h0;
        if (mq.size() != 0) h = mq[0];
        exp_en = (mq.size() != 0) && !frz && (h.d != 4'hF);
        chk("wb_en", {31'b0, wb_en}, {31'b0, exp_en});
        chk("write_src_reg", {28'b0, write_src_reg}, {28'b0, h.d});
        chk("wb_value", wb_value, h.v);
        if (wb_en === 1'b1) begin
            chk("write_expected", {31'b0, sbq.size() != 0}, 32'd1);
            if (sbq.size() != 0) begin
                w = sbq.pop_front();
                chk("sb_dest", {28'b0, write_src_reg}, {28'b0, w.d});
                chk("sb_value", wb_value, w.v);
            end
        end
        model_lookup(query_reg_1, p, f);
        chk("pending_1", {31'b0, pending_1}, {31'b0, p});
        chk("fwd_data_1", fwd_data_1, f);
        model_lookup(query_reg_2, p, f);
        chk("pending_2", {31'b0, pending_2}, {31'b0, p});
        chk("fwd_data_2", fwd_data_2, f);
        @(posedge clk);
        fire = pv && exp_ready;
        ret  = (mq.size() != 0) && !frz;
        if (ret) void'(mq.pop_front());
        if (fire) begin
            w.d = pd;
            w.v = pval;
            mq.push_back(w);
            if (pd != 4'hF) sbq.push_back(w);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pif.push_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        sbq.delete();
    endtask

    initial begin
        rst            = 1'b1;
        freeze         = 1'b0;
        pif.push_valid = 1'b0;
        pif.push_dest  = '0;
        pif.push_value = '0;
        query_reg_1    = 4'd3;
        query_reg_2    = 4'd5;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state and single push/retire latency
        cycle(1'b1, 4'd3, 32'h1234, 1'b0);
        cycle(1'b0, 4'd0, 32'h0, 1'b0);
        cycle(1'b0, 4'd0, 32'h0, 1'b0);

        // frozen fill, fifth push refused, then in-order drain
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 4'(i + 1), 32'h100 + 32'(i), 1'b1);
        chk("full_count", {29'b0, count}, 32'd4);
        cycle(1'b0, 4'd0, 32'h0, 1'b1);
        repeat (5) cycle(1'b0, 4'd0, 32'h0, 1'b0);

        // youngest-match forwarding
        cycle(1'b1, 4'd2, 32'hA, 1'b1);
        cycle(1'b1, 4'd2, 32'hB, 1'b1);
        query_reg_1 = 4'd2;
        query_reg_2 = 4'd7;
        cycle(1'b0, 4'd0, 32'h0, 1'b1);
        chk("fwd_youngest", fwd_data_1, 32'hB);
        query_reg_2 = 4'hF;
        cycle(1'b0, 4'd0, 32'h0, 1'b1);
        cycle(1'b0, 4'd0, 32'h0, 1'b0);
        repeat (2) cycle(1'b0, 4'd0, 32'h0, 1'b0);

        // PC destination occupies a slot but never writes
        cycle(1'b1, 4'hF, 32'hFFFF, 1'b0);
        cycle(1'b0, 4'd0, 32'h0, 1'b0);
        cycle(1'b0, 4'd0, 32'h0, 1'b0);

        // full + retire blocks push, then steady push/retire with wrap
        query_reg_1 = 4'd9;
        query_reg_2 = 4'd6;
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 4'(i + 4), 32'h200 + 32'(i), 1'b1);
        cycle(1'b1, 4'd8, 32'h208, 1'b0);
        chk("count_after_blocked", {29'b0, count}, 32'd3);
        for (int i = 0; i < 7; i++)
            cycle(1'b1, 4'(9 + (i % 5)), 32'h300 + 32'(i), 1'b0);
        repeat (5) cycle(1'b0, 4'd0, 32'h0, 1'b0);

        // reset discards queued results
        query_reg_1 = 4'd10;
        query_reg_2 = 4'd11;
        cycle(1'b1, 4'd10, 32'hDEAD0001, 1'b1);
        cycle(1'b1, 4'd11, 32'hDEAD0002, 1'b1);
        cycle(1'b1, 4'd10, 32'hDEAD0003, 1'b1);
        do_reset();
        repeat (4) cycle(1'b0, 4'd0, 32'h0, 1'b0);

        chk("scoreboard_drained", sbq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
